// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register with a one-entry skid buffer.
// in_ready depends only on local state, so the EX stage never waits on out_ready.
module ex_mem_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int WB_W   = 2,
  parameter int M_W    = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WB_W-1:0]   wb_ctl_in,
  input  logic [M_W-1:0]    m_ctl_in,
  input  logic [DATA_W-1:0] add_in,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] rdata2_in,
  input  logic              zero_in,
  input  logic [REG_W-1:0]  dest_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WB_W-1:0]   wb_ctl_out,
  output logic [M_W-1:0]    m_ctl_out,
  output logic [DATA_W-1:0] add_out,
  output logic [DATA_W-1:0] alu_out,
  output logic [DATA_W-1:0] rdata2_out,
  output logic              zero_out,
  output logic [REG_W-1:0]  dest_out,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic [WB_W-1:0]   wb;
    logic [M_W-1:0]    m;
    logic [DATA_W-1:0] add;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] rd2;
    logic              zero;
    logic [REG_W-1:0]  dest;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

  state_t           r_state;
  entry_t           r_main;
  entry_t           r_skid;
  logic [CNT_W-1:0] r_stall;

  entry_t w_in;
  logic   w_accept;
  logic   w_fire;

  assign w_in = '{wb: wb_ctl_in, m: m_ctl_in, add: add_in, alu: alu_in,
                  rd2: rdata2_in, zero: zero_in, dest: dest_in};

  assign in_ready  = reset && !flush && (r_state != SKID);
  assign out_valid = (r_state != EMPTY);
  assign w_accept  = in_valid && in_ready;
  assign w_fire    = out_valid && out_ready;

  // Control fields are gated so a bubble can never write a register or touch memory.
  assign wb_ctl_out = out_valid ? r_main.wb : '0;
  assign m_ctl_out  = out_valid ? r_main.m  : '0;
  assign add_out    = r_main.add;
  assign alu_out    = r_main.alu;
  assign rdata2_out = r_main.rd2;
  assign zero_out   = r_main.zero;
  assign dest_out   = r_main.dest;
  assign stall_cnt  = r_stall;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
      r_stall <= '0;
    end else begin
      if (out_valid && !out_ready && (r_stall != '1))
        r_stall <= r_stall + 1'b1;
      // Flush only drops occupancy; main data is left as-is on the outputs.
      if (flush) begin
        r_state <= EMPTY;
      end else begin
        case (r_state)
          EMPTY: if (w_accept) begin
            r_main  <= w_in;
            r_state <= FULL;
          end
          FULL: case ({w_fire, w_accept})
            2'b11: r_main <= w_in;
            2'b10: r_state <= EMPTY;
            2'b01: begin
              r_skid  <= w_in;
              r_state <= SKID;
            end
            default: ;
          endcase
          SKID: if (w_fire) begin
            r_main  <= r_skid;
            r_state <= FULL;
          end
          default: r_state <= EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Directed vector table plus hand sequences and a scoreboarded random stream.
module tb_ex_mem_pipe_reg;

  logic        clk, reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  wb_ctl_in, wb_ctl_out;
  logic [2:0]  m_ctl_in, m_ctl_out;
  logic [31:0] add_in, alu_in, rdata2_in, add_out, alu_out, rdata2_out;
  logic        zero_in, zero_out;
  logic [4:0]  dest_in, dest_out;
  logic [3:0]  stall_cnt;

  ex_mem_pipe_reg #(.DATA_W(32), .REG_W(5), .WB_W(2), .M_W(3), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .wb_ctl_in(wb_ctl_in), .m_ctl_in(m_ctl_in), .add_in(add_in), .alu_in(alu_in),
    .rdata2_in(rdata2_in), .zero_in(zero_in), .dest_in(dest_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .wb_ctl_out(wb_ctl_out), .m_ctl_out(m_ctl_out), .add_out(add_out), .alu_out(alu_out),
    .rdata2_out(rdata2_out), .zero_out(zero_out), .dest_out(dest_out), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Entry fields derived from a tag; tag 0 yields the all-zero reset image.
  task automatic drive_tag(input int t);
    logic [31:0] tv;
    tv = t;
    wb_ctl_in = tv[1:0];
    m_ctl_in  = tv[2:0];
    add_in    = tv * 32'h01010101;
    alu_in    = tv * 32'h02020202;
    rdata2_in = tv * 32'h03030303;
    zero_in   = tv[0];
    dest_in   = tv[4:0];
  endtask

  task automatic chk_tag(input string nm, input int t, input logic ov);
    logic [31:0] tv;
    tv = t;
    chk({nm, ".wb"}, 64'(wb_ctl_out), ov ? 64'(tv[1:0]) : 64'd0);
    chk({nm, ".m"}, 64'(m_ctl_out), ov ? 64'(tv[2:0]) : 64'd0);
    chk({nm, ".add_alu"}, {add_out, alu_out}, {tv * 32'h01010101, tv * 32'h02020202});
    chk({nm, ".rd2_z_dst"}, {25'd0, rdata2_out, zero_out, dest_out},
        {25'd0, tv * 32'h03030303, tv[0], tv[4:0]});
  endtask

  typedef struct {
    logic rst, fl, iv, ordy;
    int   tag;
    logic exp_rdy, exp_ov;
    int   exp_tag;
    int   exp_cnt;
  } vec_t;

  typedef struct {
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [31:0] add, alu, rd2;
    logic        zero;
    logic [4:0]  dest;
  } ent_t;

  vec_t tv[17];
  ent_t q[$];
  ent_t e, f;

  initial begin
    // rst fl iv ordy tag | rdy ov tag cnt  (rdy sampled before the edge, rest after)
    tv[0]  = '{1,0,1,0, 1, 1,1, 1,0};  // EMPTY->FULL
    tv[1]  = '{1,0,1,0, 2, 1,1, 1,1};  // FULL->SKID
    tv[2]  = '{1,0,1,0, 3, 0,1, 1,2};  // C held off
    tv[3]  = '{1,0,1,1, 3, 0,1, 2,2};  // SKID fire -> B
    tv[4]  = '{1,0,1,1, 3, 1,1, 3,2};  // fire+accept -> C
    tv[5]  = '{1,0,0,1, 0, 1,0, 3,2};  // drain; data holds
    tv[6]  = '{1,0,1,0, 4, 1,1, 4,2};
    tv[7]  = '{1,0,1,0, 5, 1,1, 4,3};  // SKID
    tv[8]  = '{1,1,1,0, 6, 0,0, 4,4};  // flush in SKID
    tv[9]  = '{1,0,1,1, 7, 1,1, 7,4};  // next entry passes
    tv[10] = '{1,0,0,1, 0, 1,0, 7,4};
    tv[11] = '{1,0,1,0, 8, 1,1, 8,4};
    tv[12] = '{1,0,1,0, 9, 1,1, 8,5};  // SKID
    tv[13] = '{0,0,1,1,10, 0,0, 0,0};  // reset in SKID
    tv[14] = '{1,0,0,1, 0, 1,0, 0,0};  // nothing leaks out
    tv[15] = '{1,0,1,1,11, 1,1,11,0};
    tv[16] = '{1,1,1,1,12, 0,0,11,0};  // flush + fire

    reset = 0; flush = 0; in_valid = 0; out_ready = 0; drive_tag(0);

    // Reset held two cycles
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ready", 64'(in_ready), 64'd0);
    chk("rst.valid", 64'(out_valid), 64'd0);
    chk("rst.cnt", 64'(stall_cnt), 64'd0);
    chk_tag("rst", 0, 1'b0);
    @(negedge clk);
    reset = 1;
    #1 chk("rst.release_ready", 64'(in_ready), 64'd1);

    // Single entry pass-through
    out_ready = 1; in_valid = 1;
    wb_ctl_in = 2'b10; m_ctl_in = 3'b111; add_in = 32'h0C; alu_in = 32'h0F;
    rdata2_in = 32'h0A; zero_in = 0; dest_in = 5'h1F;
    @(posedge clk); #1;
    chk("one.valid", 64'(out_valid), 64'd1);
    chk("one.ctl", {59'd0, wb_ctl_out, m_ctl_out}, {59'd0, 2'b10, 3'b111});
    chk("one.data", {add_out, alu_out}, {32'h0C, 32'h0F});
    chk("one.rest", {25'd0, rdata2_out, zero_out, dest_out}, {25'd0, 32'h0A, 1'b0, 5'h1F});
    @(negedge clk);
    in_valid = 0;
    @(posedge clk); #1;
    chk("one.bubble_valid", 64'(out_valid), 64'd0);
    chk("one.bubble_ctl", {59'd0, wb_ctl_out, m_ctl_out}, 64'd0);

    // Clean start for the table, so stall_cnt begins at 0
    @(negedge clk);
    reset = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1;

    foreach (tv[i]) begin
      reset = tv[i].rst; flush = tv[i].fl; in_valid = tv[i].iv; out_ready = tv[i].ordy;
      drive_tag(tv[i].tag);
      #1 chk($sformatf("v%0d.ready", i), 64'(in_ready), 64'(tv[i].exp_rdy));
      @(posedge clk); #1;
      chk($sformatf("v%0d.valid", i), 64'(out_valid), 64'(tv[i].exp_ov));
      chk($sformatf("v%0d.cnt", i), 64'(stall_cnt), 64'(tv[i].exp_cnt));
      chk_tag($sformatf("v%0d", i), tv[i].exp_tag, tv[i].exp_ov);
      @(negedge clk);
    end
    reset = 1; flush = 0; in_valid = 0;

    // Stall counter saturation with a 4-bit counter
    out_ready = 0; in_valid = 1; drive_tag(13);
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      chk($sformatf("sat.cnt%0d", i), 64'(stall_cnt), 64'((i > 15) ? 15 : i));
      @(negedge clk);
    end
    flush = 1;
    @(posedge clk); #1;
    chk("sat.flush_cnt", 64'(stall_cnt), 64'd15);
    chk("sat.flush_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    flush = 0; reset = 0;
    @(posedge clk); #1;
    chk("sat.reset_cnt", 64'(stall_cnt), 64'd0);
    @(negedge clk);
    reset = 1;

    // Random stream against an occupancy/queue model
    begin
      int sent = 0;
      int cyc = 0;
      while ((sent < 100 || q.size() != 0) && cyc < 3000) begin
        in_valid  = (sent < 100) ? ($urandom_range(0, 3) != 0) : 1'b0;
        out_ready = ($urandom_range(0, 2) != 0);
        e.wb = 2'($urandom); e.m = 3'($urandom); e.add = $urandom; e.alu = $urandom;
        e.rd2 = $urandom; e.zero = 1'($urandom); e.dest = 5'($urandom);
        wb_ctl_in = e.wb; m_ctl_in = e.m; add_in = e.add; alu_in = e.alu;
        rdata2_in = e.rd2; zero_in = e.zero; dest_in = e.dest;
        #1;
        if (in_ready !== (q.size() < 2)) chk("rnd.ready", 64'(in_ready), 64'(q.size() < 2));
        if (out_valid !== (q.size() != 0)) chk("rnd.valid", 64'(out_valid), 64'(q.size() != 0));
        if (out_valid && out_ready && q.size() != 0) begin
          f = q.pop_front();
          chk("rnd.add_alu", {add_out, alu_out}, {f.add, f.alu});
          chk("rnd.rest", {21'd0, wb_ctl_out, m_ctl_out, rdata2_out, zero_out, dest_out},
              {21'd0, f.wb, f.m, f.rd2, f.zero, f.dest});
        end
        if (in_valid && in_ready) begin
          q.push_back(e);
          sent++;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
      end
      chk("rnd.all_sent", 64'(sent), 64'd100);
      chk("rnd.drained", 64'(q.size()), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
